// File: rtl/mdu_sequencer.sv
// Iterative unsigned MULTU/DIVU unit for the EX stage: one shift/add-subtract
// step per cycle, WIDTH steps per operation, result held in HI/LO.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             op_q;
    logic [CW-1:0]    count;
    // acc is P_hi (multiply) or R (divide); sh is P_lo or Q; opnd is M or D
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        acc_nxt = acc;
        sh_nxt  = sh;
        sum     = '0;
        r_sh    = '0;
        diff    = '0;
        if (!op_q) begin
            sum     = sh[0] ? (acc + {1'b0, opnd}) : acc;
            acc_nxt = {1'b0, sum[WIDTH:1]};
            sh_nxt  = {sum[0], sh[WIDTH-1:1]};
        end else begin
            r_sh = {acc[WIDTH-1:0], sh[WIDTH-1]};
            diff = r_sh - {1'b0, opnd};
            // r_sh < 2*D, so the top bit of diff is a reliable borrow
            if (!diff[WIDTH]) begin
                acc_nxt = diff;
                sh_nxt  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = r_sh;
                sh_nxt  = {sh[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            count    <= '0;
            acc      <= '0;
            sh       <= '0;
            opnd     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        opnd     <= op ? b : a;
                        sh       <= op ? a : b;
                        acc      <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        div_zero <= op && (b == '0);
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    if (count == LAST) begin
                        hi    <= acc_nxt[WIDTH-1:0];
                        lo    <= sh_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: cycle-exact busy/done/hi/lo/div_zero checks
// against hand-computed results.
module tb_mdu_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    int checks = 0;
    int fails  = 0;
    logic [WIDTH-1:0] prev_hi = '0;
    logic [WIDTH-1:0] prev_lo = '0;

    mdu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an accept in the current cycle; returns in cycle E0+1.
    // Operands are scrambled afterwards to prove the latched copies are used.
    task automatic accept(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        op    = ~o;
        a     = ~av;
        b     = ~bv;
    endtask

    // Check cycles E0+1..E0+last; optionally pulse start in cycle pulse_at.
    task automatic run_body(input logic exp_dz, input int last, input int pulse_at);
        for (int c = 1; c <= last; c++) begin
            chk($sformatf("busy c%0d", c), 64'(busy), 64'(1'b1));
            chk($sformatf("done c%0d", c), 64'(done), 64'(1'b0));
            chk($sformatf("dz c%0d", c), 64'(div_zero), 64'(exp_dz));
            chk($sformatf("hi hold c%0d", c), 64'(hi), 64'(prev_hi));
            chk($sformatf("lo hold c%0d", c), 64'(lo), 64'(prev_lo));
            if (c == pulse_at) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'd9;
                b     = 32'd9;
            end
            if (c < last) begin
                tick();
                start = 1'b0;
            end
        end
    endtask

    // Advance into cycle E0+33 and check the result.
    task automatic finish(input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el, input logic exp_dz);
        tick();
        start = 1'b0;
        chk("done pulse", 64'(done), 64'(1'b1));
        chk("busy at done", 64'(busy), 64'(1'b0));
        chk("hi result", 64'(hi), 64'(eh));
        chk("lo result", 64'(lo), 64'(el));
        chk("dz at done", 64'(div_zero), 64'(exp_dz));
        prev_hi = eh;
        prev_lo = el;
    endtask

    task automatic idle_after(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle done", 64'(done), 64'(1'b0));
            chk("idle busy", 64'(busy), 64'(1'b0));
            chk("idle hi", 64'(hi), 64'(prev_hi));
            chk("idle lo", 64'(lo), 64'(prev_lo));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick();
        tick();
        chk("rst busy", 64'(busy), 64'(1'b0));
        chk("rst done", 64'(done), 64'(1'b0));
        chk("rst hi", 64'(hi), 64'(0));
        chk("rst lo", 64'(lo), 64'(0));
        chk("rst dz", 64'(div_zero), 64'(1'b0));
        rst = 1'b0;
        tick();

        // MULTU max * max
        accept(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_body(1'b0, 32, 0);
        finish(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        idle_after(1);

        // DIVU 100 / 7
        accept(1'b1, 32'd100, 32'd7);
        run_body(1'b0, 32, 0);
        finish(32'd2, 32'd14, 1'b0);
        idle_after(1);

        // DIVU max / 1
        accept(1'b1, 32'hFFFF_FFFF, 32'd1);
        run_body(1'b0, 32, 0);
        finish(32'd0, 32'hFFFF_FFFF, 1'b0);
        idle_after(1);

        // DIVU 5 / 0
        accept(1'b1, 32'd5, 32'd0);
        run_body(1'b1, 32, 0);
        finish(32'd5, 32'hFFFF_FFFF, 1'b1);
        idle_after(1);
        chk("dz sticky idle", 64'(div_zero), 64'(1'b1));

        // MULTU 3*5 clears div_zero; start pulse in cycle 10 must be ignored
        accept(1'b0, 32'd3, 32'd5);
        run_body(1'b0, 32, 10);
        finish(32'd0, 32'd15, 1'b0);
        idle_after(3);

        // DIVU 1000/3 abandoned by reset in cycle 20, with start also high
        accept(1'b1, 32'd1000, 32'd3);
        run_body(1'b0, 20, 0);
        rst   = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd2;
        b     = 32'd2;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("mid rst busy", 64'(busy), 64'(1'b0));
        chk("mid rst done", 64'(done), 64'(1'b0));
        chk("mid rst hi", 64'(hi), 64'(0));
        chk("mid rst lo", 64'(lo), 64'(0));
        chk("mid rst dz", 64'(div_zero), 64'(1'b0));
        prev_hi = '0;
        prev_lo = '0;
        idle_after(2);

        // MULTU 3*4 after reset
        accept(1'b0, 32'd3, 32'd4);
        run_body(1'b0, 32, 0);
        finish(32'd0, 32'd12, 1'b0);
        idle_after(1);

        // Back-to-back: MULTU 6*7 then DIVU 50/8 accepted in the DONE cycle
        accept(1'b0, 32'd6, 32'd7);
        run_body(1'b0, 32, 0);
        finish(32'd0, 32'd42, 1'b0);
        accept(1'b1, 32'd50, 32'd8);
        run_body(1'b0, 32, 0);
        finish(32'd2, 32'd6, 1'b0);
        idle_after(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
